mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised, clocked round-robin arbiter between NUM_PORTS cache-side requesters and the single line-wide main memory port. It replaces the two-port, level-triggered instruction/data-cache arbiter. Every transaction is registered, every outcome is signalled to the owning port, and fairness is guaranteed. It sits between the L1 caches (port 0 = dcache, port 1 = icache by convention) and the memory model.

## Interface
- NUM_PORTS, 2: number of requesters, at least 2.
- ADDR_W, MEMORY_ADDRESS_SIZE: address width.
- LINE_W, CACHE_LINE_SIZE: data width, one cache line.
- TIMEOUT_CYCLES, 256: watchdog limit. Used only with MEM_ARB_TIMEOUT_EN.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  NUM_PORTS  per-port request level.
- op  in  NUM_PORTS  per-port operation: 0 = read, 1 = write.
- addr  in  NUM_PORTS*ADDR_W  per-port address. Port i occupies slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*LINE_W  per-port write line. Same slicing as addr.
- grant  out  NUM_PORTS  one-hot owner of the current transaction.
- ready  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- rdata  out  LINE_W  last read line returned by memory.
- err  out  1  completion was a timeout. Qualified by ready.
- mem_enable  out  1  memory request level.
- mem_op  out  1  0 = read, 1 = write.
- mem_address  out  ADDR_W  registered address.
- mem_data_in  out  LINE_W  registered write line.
- mem_data_ready  in  1  memory completion, synchronous to clk.
- mem_data_out  in  LINE_W  read line, valid while mem_data_ready is high.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset puts it in IDLE.
- **IDLE:**
  - If any req bit is high, the rotating-priority pick selects the first requesting port at or after `ptr`, wrapping modulo NUM_PORTS.
  - On that edge the arbiter latches the port's op, addr and wdata into mem_op, mem_address and mem_data_in.
  - It sets grant[i] = 1, sets mem_enable = 1, and goes to BUSY.
  - It sets `ptr` to (i+1) mod NUM_PORTS.
- **BUSY:**
  - mem_enable and grant are held.
  - When mem_data_ready is sampled high, a read captures mem_data_out into rdata; a write leaves rdata unchanged.
  - On the same edge mem_enable goes to 0 and the FSM goes to DONE.
- **DONE:**
  - ready[i] = 1 for exactly this cycle, with grant[i] still high. Then the FSM returns to IDLE and grant goes to 0.
  - Writes also pulse ready.
- **Requester rule:** drop req in the cycle after ready. A req still high in IDLE is a new request.
- **Requester rule:** hold op, addr and wdata stable from raising req until grant.
- mem_data_ready is ignored in IDLE and DONE. Late or spurious pulses have no effect.
- A request that loses arbitration simply stays pending. No starvation: with all ports requesting, each port waits at most NUM_PORTS-1 transactions.
- **Reset mid-operation:** rst_n low immediately clears everything below. A memory response arriving after reset is ignored.
  - state → IDLE, ptr → 0.
  - grant, ready, err, mem_enable, mem_op → 0.
  - mem_address, mem_data_in, rdata → 0.

## Timing
- Request at edge T0 (IDLE): grant and mem_enable are high from T0+1.
- mem_data_ready sampled high at edge Tk: ready is high during cycle Tk..Tk+1, and grant is low after Tk+1.
- Minimum request→ready latency is 2 cycles, when mem_data_ready is high on the first BUSY edge.
- Back-to-back transactions have one IDLE cycle between them. Memory sees mem_enable low for at least 2 cycles between operations.
- All outputs are registered. No combinational path from req or mem_data_ready to any output.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_data_ready, the arbiter drops mem_enable and goes to DONE.
  - In DONE it pulses ready[i] with err = 1. rdata is unchanged.
- MEM_ARB_TIMEOUT_EN undefined: there is no counter, err is tied to 0, and BUSY waits indefinitely.

## Structure
- The shared include src/parameters.v holds:
  - MEMORY_ADDRESS_SIZE and CACHE_LINE_SIZE.
  - The op encodings MEM_OP_READ = 0 and MEM_OP_WRITE = 1.
  - The state encodings ARB_IDLE, ARB_BUSY, ARB_DONE.
- Sub-module rr_pick(NUM_PORTS) is combinational:
  - Inputs: req and ptr.
  - Outputs: one-hot pick and its index.
  - It is implemented with a double-width masked priority encoder.

## Test plan
- **Single read:** port 1 reads addr 0x40; memory asserts mem_data_ready 3 cycles after mem_enable with data 0xDEADBEEF.
  - Required: mem_address = 0x40, mem_op = 0, grant = 2'b10.
  - Required: ready[1] pulses once, rdata = 0xDEADBEEF, err = 0.
- **Simultaneous requests, 2 ports, after reset:**
  - Port 0 is served first, then port 1.
  - A further simultaneous request goes to port 0 again.
- **Write:** port 0 writes line 0xA5…A5 to 0x100.
  - Required: mem_op = 1, mem_data_in = 0xA5…A5.
  - Required: ready[0] pulses, rdata keeps its previous value.
- **Fairness, NUM_PORTS = 4:** all req held high.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each ready pulse is exactly 1 cycle.
- **Reset mid-BUSY:**
  - When rst_n goes low, all outputs are 0 without waiting for a clock edge.
  - A mem_data_ready pulse after release produces no ready and no rdata change.
- **Timeout:** MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, memory silent.
  - ready and err are both high 9 cycles after grant rises.
  - Without the macro, grant stays high for more than 100 cycles.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg: shared sizes, memory op encodings and arbiter state encodings
package mem_arbiter_rr_pkg;

    localparam int MEMORY_ADDRESS_SIZE = 32;
    localparam int CACHE_LINE_SIZE     = 128;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side and memory-side signals of the round-robin memory arbiter
interface mem_arbiter_rr_if
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = MEMORY_ADDRESS_SIZE,
    parameter int LINE_W    = CACHE_LINE_SIZE
);

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        op;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*LINE_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS-1:0]        ready;
    logic [LINE_W-1:0]           rdata;
    logic                        err;
    logic                        mem_enable;
    logic                        mem_op;
    logic [ADDR_W-1:0]           mem_address;
    logic [LINE_W-1:0]           mem_data_in;
    logic                        mem_data_ready;
    logic [LINE_W-1:0]           mem_data_out;

    modport slave (
        input  req, op, addr, wdata, mem_data_ready, mem_data_out,
        output grant, ready, rdata, err, mem_enable, mem_op, mem_address, mem_data_in
    );

    modport master (
        output req, op, addr, wdata, mem_data_ready, mem_data_out,
        input  grant, ready, rdata, err, mem_enable, mem_op, mem_address, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// mem_arbiter_rr_pick: rotating-priority pick, first requester at or after ptr, via a double-width masked priority encoder
module mem_arbiter_rr_pick #(
    parameter  int NUM_PORTS = 2,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] pick,
    output logic [PW-1:0]        idx
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic                   found;

    assign dbl = {req, req};

    // Lowest set bit of the doubled request vector at or above ptr, folded back modulo NUM_PORTS
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < 2 * NUM_PORTS; j++)
            if (!found && dbl[j] && j >= int'(ptr)) begin
                found = 1'b1;
                idx   = PW'(j % NUM_PORTS);
            end
        pick = found ? NUM_PORTS'(1) << idx : '0;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: registered round-robin arbiter of NUM_PORTS cache ports onto one line-wide memory port; MEM_ARB_TIMEOUT_EN adds a BUSY watchdog
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = MEMORY_ADDRESS_SIZE,
    parameter int LINE_W         = CACHE_LINE_SIZE,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_rr_if.slave bus
);

    localparam int PW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_arbiter_rr: NUM_PORTS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t           state, nxt;
    logic [PW-1:0]        ptr, idx;
    logic [NUM_PORTS-1:0] pick;
    logic                 tmo, fin;

    assign fin = bus.mem_data_ready || tmo;

    mem_arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ARB_IDLE;
        else        state <= nxt;

    // Next state: arbitrate in IDLE, wait for memory (or watchdog) in BUSY, one completion cycle in DONE
    always_comb begin
        nxt = ARB_IDLE;
        nxt = state == ARB_IDLE ? (|bus.req ? ARB_BUSY : ARB_IDLE) :
              state == ARB_BUSY ? (fin ? ARB_DONE : ARB_BUSY) : ARB_IDLE;
    end

    // Registered outputs: latch the winner's command on grant, finish on response, release after the ready cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            bus.grant       <= '0;
            bus.ready       <= '0;
            bus.mem_enable  <= 1'b0;
            bus.mem_op      <= MEM_OP_READ;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.rdata       <= '0;
        end else if (state == ARB_IDLE) begin
            if (|bus.req) begin
                bus.grant       <= pick;
                bus.mem_enable  <= 1'b1;
                bus.mem_op      <= bus.op[idx];
                bus.mem_address <= bus.addr[int'(idx) * ADDR_W +: ADDR_W];
                bus.mem_data_in <= bus.wdata[int'(idx) * LINE_W +: LINE_W];
                ptr             <= idx == PW'(NUM_PORTS - 1) ? '0 : idx + 1'b1;
            end
        end else if (state == ARB_BUSY) begin
            if (fin) begin
                bus.mem_enable <= 1'b0;
                bus.ready      <= bus.grant;
                if (bus.mem_data_ready && bus.mem_op == MEM_OP_READ) bus.rdata <= bus.mem_data_out;
            end
        end else begin
            bus.grant <= '0;
            bus.ready <= '0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign tmo = state == ARB_BUSY && cnt == CW'(TIMEOUT_CYCLES);

    // Watchdog: count BUSY cycles from zero and flag a completion that the memory never answered
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            bus.err <= 1'b0;
        end else begin
            cnt     <= state == ARB_BUSY ? cnt + 1'b1 : '0;
            bus.err <= tmo && !bus.mem_data_ready;
        end
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed self-checking bench for mem_arbiter_rr (2-port and 4-port instances)
module tb_mem_arbiter_rr;

    localparam logic [127:0] A5 = {16{8'hA5}};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_PORTS(2)) b2 ();
    mem_arbiter_rr_if #(.NUM_PORTS(4)) b4 ();

    mem_arbiter_rr #(.NUM_PORTS(2), .TIMEOUT_CYCLES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_arbiter_rr #(.NUM_PORTS(4), .TIMEOUT_CYCLES(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b2.req = '0; b2.op = '0; b2.addr = '0; b2.wdata = '0; b2.mem_data_ready = 1'b0; b2.mem_data_out = '0;
        b4.req = '0; b4.op = '0; b4.addr = '0; b4.wdata = '0; b4.mem_data_ready = 1'b0; b4.mem_data_out = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        checks++; if (b2.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", b2.grant); end
        checks++; if (b2.ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", b2.ready); end
        checks++; if (b2.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", b2.err); end
        checks++; if (b2.mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_enable got=%b exp=0", b2.mem_enable); end
        checks++; if (b2.mem_op !== 1'b0) begin errors++; $display("FAIL reset_mem_op got=%b exp=0", b2.mem_op); end
        checks++; if (b2.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", b2.mem_address); end
        checks++; if (b2.mem_data_in !== 128'h0) begin errors++; $display("FAIL reset_mem_data_in got=%h exp=0", b2.mem_data_in); end
        checks++; if (b2.rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", b2.rdata); end
        checks++; if (b4.grant !== 4'h0) begin errors++; $display("FAIL reset_grant4 got=%b exp=0000", b4.grant); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (b2.grant !== 2'b00 || b2.mem_enable !== 1'b0) begin errors++; $display("FAIL idle_no_req got grant=%b en=%b exp 00/0", b2.grant, b2.mem_enable); end
    endtask

    task automatic test_single_read;
        b2.op = 2'b00;
        b2.addr[32 +: 32] = 32'h40;
        b2.req = 2'b10;
        tick();
        checks++; if (b2.grant !== 2'b10) begin errors++; $display("FAIL read_grant got=%b exp=10", b2.grant); end
        checks++; if (b2.mem_enable !== 1'b1) begin errors++; $display("FAIL read_mem_enable got=%b exp=1", b2.mem_enable); end
        checks++; if (b2.mem_address !== 32'h40) begin errors++; $display("FAIL read_mem_address got=%h exp=40", b2.mem_address); end
        checks++; if (b2.mem_op !== 1'b0) begin errors++; $display("FAIL read_mem_op got=%b exp=0", b2.mem_op); end
        tick();
        tick();
        checks++; if (b2.ready !== 2'b00 || b2.grant !== 2'b10) begin errors++; $display("FAIL read_wait got ready=%b grant=%b exp 00/10", b2.ready, b2.grant); end
        b2.mem_data_out = 128'hDEADBEEF;
        b2.mem_data_ready = 1'b1;
        tick();
        checks++; if (b2.ready !== 2'b10) begin errors++; $display("FAIL read_ready got=%b exp=10", b2.ready); end
        checks++; if (b2.grant !== 2'b10) begin errors++; $display("FAIL read_grant_in_done got=%b exp=10", b2.grant); end
        checks++; if (b2.rdata !== 128'hDEADBEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", b2.rdata); end
        checks++; if (b2.err !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", b2.err); end
        checks++; if (b2.mem_enable !== 1'b0) begin errors++; $display("FAIL read_enable_drop got=%b exp=0", b2.mem_enable); end
        b2.mem_data_ready = 1'b0;
        b2.mem_data_out = '0;
        b2.req = 2'b00;
        tick();
        checks++; if (b2.ready !== 2'b00 || b2.grant !== 2'b00) begin errors++; $display("FAIL read_release got ready=%b grant=%b exp 00/00", b2.ready, b2.grant); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        b2.op = 2'b00;
        b2.addr = {32'h200, 32'h100};
        b2.req = 2'b11;
        tick();
        checks++; if (b2.grant !== 2'b01 || b2.mem_address !== 32'h100) begin errors++; $display("FAIL simul_first got grant=%b addr=%h exp 01/100", b2.grant, b2.mem_address); end
        b2.mem_data_out = 128'h1111;
        b2.mem_data_ready = 1'b1;
        tick();
        checks++; if (b2.ready !== 2'b01 || b2.rdata !== 128'h1111) begin errors++; $display("FAIL simul_first_ready got ready=%b rdata=%h exp 01/1111", b2.ready, b2.rdata); end
        b2.mem_data_ready = 1'b0;
        b2.req = 2'b10;
        tick();
        tick();
        checks++; if (b2.grant !== 2'b10 || b2.mem_address !== 32'h200) begin errors++; $display("FAIL simul_second got grant=%b addr=%h exp 10/200", b2.grant, b2.mem_address); end
        b2.mem_data_out = 128'h2222;
        b2.mem_data_ready = 1'b1;
        tick();
        checks++; if (b2.ready !== 2'b10 || b2.rdata !== 128'h2222) begin errors++; $display("FAIL simul_second_ready got ready=%b rdata=%h exp 10/2222", b2.ready, b2.rdata); end
        b2.mem_data_ready = 1'b0;
        b2.req = 2'b00;
        tick();
        b2.req = 2'b11;
        tick();
        checks++; if (b2.grant !== 2'b01) begin errors++; $display("FAIL simul_wrap got=%b exp=01", b2.grant); end
        b2.mem_data_out = 128'h3333;
        b2.mem_data_ready = 1'b1;
        tick();
        checks++; if (b2.ready !== 2'b01 || b2.rdata !== 128'h3333) begin errors++; $display("FAIL simul_wrap_ready got ready=%b rdata=%h exp 01/3333", b2.ready, b2.rdata); end
        b2.mem_data_ready = 1'b0;
        b2.req = 2'b00;
        tick();
    endtask

    task automatic test_write;
        b2.op = 2'b01;
        b2.addr[0 +: 32] = 32'h100;
        b2.wdata[0 +: 128] = A5;
        b2.req = 2'b01;
        tick();
        checks++; if (b2.grant !== 2'b01) begin errors++; $display("FAIL write_grant got=%b exp=01", b2.grant); end
        checks++; if (b2.mem_op !== 1'b1) begin errors++; $display("FAIL write_mem_op got=%b exp=1", b2.mem_op); end
        checks++; if (b2.mem_data_in !== A5) begin errors++; $display("FAIL write_mem_data_in got=%h exp=%h", b2.mem_data_in, A5); end
        checks++; if (b2.mem_address !== 32'h100) begin errors++; $display("FAIL write_mem_address got=%h exp=100", b2.mem_address); end
        b2.mem_data_out = 128'hBAD;
        b2.mem_data_ready = 1'b1;
        tick();
        checks++; if (b2.ready !== 2'b01) begin errors++; $display("FAIL write_ready got=%b exp=01", b2.ready); end
        checks++; if (b2.rdata !== 128'h3333) begin errors++; $display("FAIL write_rdata_kept got=%h exp=3333", b2.rdata); end
        b2.mem_data_ready = 1'b0;
        b2.req = 2'b00;
        b2.op = 2'b00;
        tick();
        checks++; if (b2.ready !== 2'b00) begin errors++; $display("FAIL write_ready_pulse got=%b exp=00", b2.ready); end
    endtask

    task automatic test_reset_mid_busy;
        b2.op = 2'b10;
        b2.addr[32 +: 32] = 32'h80;
        b2.wdata[128 +: 128] = 128'h77;
        b2.req = 2'b10;
        tick();
        checks++; if (b2.grant !== 2'b10 || b2.mem_op !== 1'b1) begin errors++; $display("FAIL rstbusy_setup got grant=%b op=%b exp 10/1", b2.grant, b2.mem_op); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (b2.grant !== 2'b00) begin errors++; $display("FAIL rstbusy_grant got=%b exp=00", b2.grant); end
        checks++; if (b2.mem_enable !== 1'b0) begin errors++; $display("FAIL rstbusy_mem_enable got=%b exp=0", b2.mem_enable); end
        checks++; if (b2.mem_op !== 1'b0) begin errors++; $display("FAIL rstbusy_mem_op got=%b exp=0", b2.mem_op); end
        checks++; if (b2.mem_address !== 32'h0) begin errors++; $display("FAIL rstbusy_mem_address got=%h exp=0", b2.mem_address); end
        checks++; if (b2.mem_data_in !== 128'h0) begin errors++; $display("FAIL rstbusy_mem_data_in got=%h exp=0", b2.mem_data_in); end
        checks++; if (b2.rdata !== 128'h0) begin errors++; $display("FAIL rstbusy_rdata got=%h exp=0", b2.rdata); end
        checks++; if (b2.ready !== 2'b00 || b2.err !== 1'b0) begin errors++; $display("FAIL rstbusy_ready_err got ready=%b err=%b exp 00/0", b2.ready, b2.err); end
        b2.req = 2'b00;
        b2.op = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        b2.mem_data_out = 128'h5555;
        b2.mem_data_ready = 1'b1;
        tick();
        b2.mem_data_ready = 1'b0;
        tick();
        checks++; if (b2.ready !== 2'b00 || b2.grant !== 2'b00) begin errors++; $display("FAIL rstbusy_late_resp got ready=%b grant=%b exp 00/00", b2.ready, b2.grant); end
        checks++; if (b2.rdata !== 128'h0) begin errors++; $display("FAIL rstbusy_late_rdata got=%h exp=0", b2.rdata); end
    endtask

    task automatic test_fairness;
        logic [3:0] exp;
        int         n;
        do_reset();
        b4.req = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp = 4'b0001 << (k % 4);
            n = 0;
            while (b4.grant === 4'h0 && n < 5) begin
                tick();
                n++;
            end
            checks++; if (b4.grant !== exp) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, b4.grant, exp); end
            b4.mem_data_ready = 1'b1;
            tick();
            checks++; if (b4.ready !== exp || b4.mem_enable !== 1'b0) begin errors++; $display("FAIL fair_ready%0d got ready=%b en=%b exp %b/0", k, b4.ready, b4.mem_enable, exp); end
            b4.mem_data_ready = 1'b0;
            tick();
            checks++; if (b4.ready !== 4'h0 || b4.grant !== 4'h0) begin errors++; $display("FAIL fair_pulse%0d got ready=%b grant=%b exp 0000/0000", k, b4.ready, b4.grant); end
        end
        b4.req = 4'h0;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        b2.op = 2'b00;
        b2.addr[0 +: 32] = 32'h300;
        b2.req = 2'b01;
        tick();
        checks++; if (b2.grant !== 2'b01) begin errors++; $display("FAIL tmo_grant got=%b exp=01", b2.grant); end
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (8) tick();
        checks++; if (b2.ready !== 2'b00) begin errors++; $display("FAIL tmo_early got=%b exp=00", b2.ready); end
        tick();
        checks++; if (b2.ready !== 2'b01 || b2.err !== 1'b1) begin errors++; $display("FAIL tmo_fire got ready=%b err=%b exp 01/1", b2.ready, b2.err); end
        checks++; if (b2.rdata !== 128'h0) begin errors++; $display("FAIL tmo_rdata got=%h exp=0", b2.rdata); end
        b2.req = 2'b00;
        tick();
        checks++; if (b2.ready !== 2'b00 || b2.err !== 1'b0) begin errors++; $display("FAIL tmo_clear got ready=%b err=%b exp 00/0", b2.ready, b2.err); end
`else
        begin
            int held;
            held = 0;
            for (int c = 0; c < 101; c++) begin
                tick();
                if (b2.grant === 2'b01 && b2.ready === 2'b00) held++;
            end
            checks++; if (held !== 101) begin errors++; $display("FAIL notmo_hold got=%0d exp=101", held); end
            checks++; if (b2.err !== 1'b0) begin errors++; $display("FAIL notmo_err got=%b exp=0", b2.err); end
        end
        do_reset();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_reset_mid_busy();
        test_fairness();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
